axi_pixel_bram_responder: RTL and testbench

- AXI4-Lite write-channel responder (slave) that receives pixel words from the SD-card image loader's AXI write master.
- Commits each accepted word to the display pixel BRAM through a simple write port and returns a B response.
- Counts committed pixels and pulses a frame-complete flag so the LED display scanner knows a full image has been loaded.
- Sits between the SD image loader and the display BRAM inside the sd_card IP.

---
 rtl/axi_pixel_bram_responder.sv | 165 ++++++++++++++++
 tb/tb_axi_pixel_bram_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pixel_bram_responder.sv
// AXI4-Lite write-channel responder for the SD image loader.
// Each accepted address/data pair is committed to the display pixel BRAM
// and answered with a B response. The block also counts committed pixels
// and pulses FRAME_DONE when a full frame has been loaded.
module axi_pixel_bram_responder #(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] BRAM_SPAN    = 32'h0000_3000,
    parameter int unsigned FRAME_PIXELS = 4096
) (
    input  logic                  CLK100MHZ,
    input  logic                  RST_SYS,
    input  logic [31:0]           S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic                  S_AXI_WVALID,
    input  logic [3:0]            S_AXI_WSTRB,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    output logic                  BRAM_EN,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [31:0]           BRAM_DIN,
    output logic                  FRAME_DONE,
    output logic [15:0]           PIX_COUNT,
    output logic                  ERR_SEEN
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [16:0] FRAME_WRAP = 17'(FRAME_PIXELS);

    state_t state;
    state_t state_next;

    logic [31:0]           offset;
    logic                  addr_in_range;
    logic                  both_valid;

    logic [ADDR_WIDTH-1:0] offset_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  in_range_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [31:0]           bram_din_q;
    logic [15:0]           pix_count_q;
    logic                  frame_done_q;
    logic                  err_seen_q;
    logic [16:0]           pix_inc;

    // The loader only drops its valids on a joint ready, so both channels
    // are taken together; the range check is done on the raw address.
    assign both_valid    = S_AXI_AWVALID && S_AXI_WVALID;
    assign offset        = S_AXI_AWADDR - BASE_ADDR;
    assign addr_in_range = (S_AXI_AWADDR >= BASE_ADDR) && (offset < BRAM_SPAN);
    assign pix_inc       = {1'b0, pix_count_q} + 17'd1;

    // State register
    always_ff @(posedge CLK100MHZ or negedge RST_SYS) begin
        if (!RST_SYS) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, write, respond, wait for BREADY
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (both_valid) state_next = ACCEPT;
            ACCEPT:  state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    if (S_AXI_BREADY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: readies, BRAM strobes and B channel follow the state
    always_comb begin
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = 2'b00;
        BRAM_EN       = 1'b0;
        BRAM_WE       = 4'b0000;
        case (state)
            ACCEPT: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
            end
            WRITE: begin
                BRAM_EN = in_range_q;
                BRAM_WE = in_range_q ? wstrb_q : 4'b0000;
            end
            RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = in_range_q ? 2'b00 : 2'b10;
            end
            default: ;
        endcase
    end

    // Capture registers, BRAM address/data, pixel counter and error flag
    always_ff @(posedge CLK100MHZ or negedge RST_SYS) begin
        if (!RST_SYS) begin
            offset_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            in_range_q   <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            pix_count_q  <= '0;
            frame_done_q <= 1'b0;
            err_seen_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (both_valid) begin
                        offset_q   <= offset[ADDR_WIDTH-1:0];
                        wdata_q    <= S_AXI_WDATA;
                        wstrb_q    <= S_AXI_WSTRB;
                        in_range_q <= addr_in_range;
                    end
                end
                ACCEPT: begin
                    if (in_range_q) begin
                        bram_addr_q <= offset_q;
                        bram_din_q  <= wdata_q;
                        if (wstrb_q != 4'b0000) begin
                            if (pix_inc == FRAME_WRAP) begin
                                pix_count_q  <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                pix_count_q <= pix_inc[15:0];
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!in_range_q) begin
                        err_seen_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BRAM_ADDR  = bram_addr_q;
    assign BRAM_DIN   = bram_din_q;
    assign FRAME_DONE = frame_done_q;
    assign PIX_COUNT  = pix_count_q;
    assign ERR_SEEN   = err_seen_q;

endmodule

// File: tb/tb_axi_pixel_bram_responder.sv
// Directed testbench for axi_pixel_bram_responder, built with a four-pixel
// frame so the frame wrap is reachable in a handful of writes.
module tb_axi_pixel_bram_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic [3:0]  wstrb;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [15:0] bram_addr;
    logic [31:0] bram_din;
    logic        frame_done;
    logic [15:0] pix_count;
    logic        err_seen;

    int total = 0;
    int bad   = 0;

    axi_pixel_bram_responder #(
        .ADDR_WIDTH   (16),
        .BASE_ADDR    (BASE),
        .BRAM_SPAN    (32'h0000_3000),
        .FRAME_PIXELS (4)
    ) dut (
        .CLK100MHZ     (clk),
        .RST_SYS       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .BRAM_EN       (bram_en),
        .BRAM_WE       (bram_we),
        .BRAM_ADDR     (bram_addr),
        .BRAM_DIN      (bram_din),
        .FRAME_DONE    (frame_done),
        .PIX_COUNT     (pix_count),
        .ERR_SEEN      (err_seen)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one address/data pair, wait (bounded) for the joint ready,
    // complete the handshake and return positioned in the BRAM write cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (awready) break;
        end
        checkOutput("handshake_ready", 32'(awready & wready), 32'h1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    initial begin
        logic [15:0] wrap_pix [5];
        logic        wrap_done [5];
        wrap_pix  = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        wrap_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n   = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wvalid  = 1'b0;
        wstrb   = '0;
        bready  = 1'b0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_awready", 32'(awready), 32'h0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'h0);
        checkOutput("rst_bram_en", 32'(bram_en), 32'h0);
        checkOutput("rst_pix", 32'(pix_count), 32'h0);
        checkOutput("rst_err", 32'(err_seen), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single write, cycle by cycle
        $display("[TB] single write");
        bready  = 1'b1;
        awaddr  = BASE + 32'h6;
        wdata   = 32'h00A1_B2C3;
        wstrb   = 4'b0111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        checkOutput("s1_awready", 32'(awready), 32'h1);
        checkOutput("s1_wready", 32'(wready), 32'h1);
        checkOutput("s1_en_early", 32'(bram_en), 32'h0);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("s1_readies_drop", 32'(awready | wready), 32'h0);
        checkOutput("s1_en", 32'(bram_en), 32'h1);
        checkOutput("s1_we", 32'(bram_we), 32'h7);
        checkOutput("s1_addr", 32'(bram_addr), 32'h6);
        checkOutput("s1_din", bram_din, 32'h00A1_B2C3);
        checkOutput("s1_pix", 32'(pix_count), 32'h1);
        tick();
        checkOutput("s1_bvalid", 32'(bvalid), 32'h1);
        checkOutput("s1_bresp", 32'(bresp), 32'h0);
        checkOutput("s1_en_off", 32'(bram_en), 32'h0);
        tick();
        checkOutput("s1_bvalid_off", 32'(bvalid), 32'h0);

        // Staggered valids: address alone must not be accepted
        $display("[TB] staggered valids");
        awaddr  = BASE + 32'h10;
        wdata   = 32'h0011_2233;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stag_no_ready", 32'(awready | wready), 32'h0);
        end
        wvalid = 1'b1;
        tick();
        checkOutput("stag_ready", 32'(awready & wready), 32'h1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("stag_en", 32'(bram_en), 32'h1);
        checkOutput("stag_addr", 32'(bram_addr), 32'h10);
        checkOutput("stag_pix", 32'(pix_count), 32'h2);
        tick();
        checkOutput("stag_en_single", 32'(bram_en), 32'h0);
        checkOutput("stag_bresp", 32'(bresp), 32'h0);
        tick();

        // Out of range: first offset past the span
        $display("[TB] out of range");
        applyStimulus(BASE + 32'h3000, 32'h00FF_FFFF, 4'b1111);
        checkOutput("oor_en", 32'(bram_en), 32'h0);
        checkOutput("oor_we", 32'(bram_we), 32'h0);
        checkOutput("oor_pix", 32'(pix_count), 32'h2);
        tick();
        checkOutput("oor_bvalid", 32'(bvalid), 32'h1);
        checkOutput("oor_bresp", 32'(bresp), 32'h2);
        checkOutput("oor_err", 32'(err_seen), 32'h1);
        tick();
        checkOutput("oor_err_sticky", 32'(err_seen), 32'h1);

        // Back-pressure with the next pair already waiting
        $display("[TB] back-pressure");
        bready = 1'b0;
        applyStimulus(BASE + 32'h20, 32'h00C0_FFEE, 4'b0111);
        checkOutput("bp_pix", 32'(pix_count), 32'h3);
        tick();
        awaddr  = BASE + 32'h24;
        wdata   = 32'h0012_3456;
        wstrb   = 4'b1111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_bvalid_hold", 32'(bvalid), 32'h1);
            checkOutput("bp_bresp_hold", 32'(bresp), 32'h0);
            checkOutput("bp_no_accept", 32'(awready | wready), 32'h0);
            tick();
        end
        bready = 1'b1;
        tick();
        checkOutput("bp_bvalid_clr", 32'(bvalid), 32'h0);
        checkOutput("bp_idle_no_ready", 32'(awready), 32'h0);
        tick();
        checkOutput("bp_next_ready", 32'(awready & wready), 32'h1);
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        checkOutput("bp_next_addr", 32'(bram_addr), 32'h24);
        checkOutput("bp_next_pix", 32'(pix_count), 32'h0);
        checkOutput("bp_next_frame", 32'(frame_done), 32'h1);
        tick();
        checkOutput("bp_frame_pulse", 32'(frame_done), 32'h0);
        checkOutput("bp_fast_bvalid", 32'(bvalid), 32'h1);
        tick();
        checkOutput("bp_fast_bvalid_off", 32'(bvalid), 32'h0);

        // Zero strobe: enable without write, no count
        $display("[TB] zero strobe");
        applyStimulus(BASE + 32'h30, 32'h0055_5555, 4'b0000);
        checkOutput("z_en", 32'(bram_en), 32'h1);
        checkOutput("z_we", 32'(bram_we), 32'h0);
        checkOutput("z_pix", 32'(pix_count), 32'h0);
        tick();
        checkOutput("z_bresp", 32'(bresp), 32'h0);
        tick();

        // Frame wrap from a clean counter
        $display("[TB] frame wrap");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("wrap_start_pix", 32'(pix_count), 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(BASE + 32'(i), 32'h0000_0100 + 32'(i), 4'b0111);
            checkOutput("wrap_pix", 32'(pix_count), 32'(wrap_pix[i]));
            checkOutput("wrap_done", 32'(frame_done), 32'(wrap_done[i]));
            tick();
            checkOutput("wrap_done_off", 32'(frame_done), 32'h0);
            tick();
        end

        // Async reset in RESP, preceded by a below-base SLVERR
        $display("[TB] async reset");
        applyStimulus(BASE - 32'h4, 32'h0000_0001, 4'b1111);
        checkOutput("below_en", 32'(bram_en), 32'h0);
        tick();
        checkOutput("below_bresp", 32'(bresp), 32'h2);
        tick();
        bready = 1'b0;
        applyStimulus(BASE + 32'h8, 32'h0077_8899, 4'b1111);
        tick();
        checkOutput("ar_bvalid_pre", 32'(bvalid), 32'h1);
        checkOutput("ar_pix_pre", 32'(pix_count), 32'h2);
        checkOutput("ar_err_pre", 32'(err_seen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_bvalid", 32'(bvalid), 32'h0);
        checkOutput("ar_pix", 32'(pix_count), 32'h0);
        checkOutput("ar_err", 32'(err_seen), 32'h0);
        checkOutput("ar_addr", 32'(bram_addr), 32'h0);
        checkOutput("ar_din", bram_din, 32'h0);
        tick();
        rst_n  = 1'b1;
        bready = 1'b1;
        tick();
        applyStimulus(BASE + 32'h2, 32'h0013_5790, 4'b1111);
        checkOutput("post_en", 32'(bram_en), 32'h1);
        checkOutput("post_addr", 32'(bram_addr), 32'h2);
        checkOutput("post_din", bram_din, 32'h0013_5790);
        checkOutput("post_pix", 32'(pix_count), 32'h1);
        tick();
        checkOutput("post_bvalid", 32'(bvalid), 32'h1);
        checkOutput("post_bresp", 32'(bresp), 32'h0);
        tick();
        checkOutput("post_idle", 32'(bvalid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
